// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI (mode 0) slave controller feeding a 16 x 8-bit config
// register file. The SPI pins are oversampled on clk. Writes go to shadow
// registers. Shadow is copied to the active set (cfg) on an idle frame_sync,
// so the renderer never sees a half-written parameter set.
//
// Ports
//   clk         system clock (>= 8x SCLK)
//   reset       asynchronous, active-high
//   SCLK/SSEL/MOSI  raw SPI pins (asynchronous to clk)
//   frame_sync  one-clk pulse at start of vertical blank
//   MISO        SPI data out (tied 0 unless SPI_READBACK_EN)
//   cfg         active registers, reg n at [8n+7:8n]
//   wr_strobe   one-clk pulse per shadow write
//   commit      one-clk pulse when shadow is copied to active
//   busy        synchronized SSEL
//
// Build option: define SPI_READBACK_EN to support read commands (cmd[7]=1).
// Without it, read commands consume bytes silently and MISO is 0.
//
// state   | meaning
// IDLE    | SSEL low; bit counter and shifters cleared
// CMD     | shifting in the command byte
// WDATA   | each completed byte writes shadow[addr], addr++
// RDATA   | each byte boundary reloads the read shifter, addr++
// IGNORE  | read command without readback support; bytes discarded
module spi_reg_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         SCLK,
  input  logic         SSEL,
  input  logic         MOSI,
  input  logic         frame_sync,
  output logic         MISO,
  output logic [127:0] cfg,
  output logic         wr_strobe,
  output logic         commit,
  output logic         busy
);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA, ST_IGNORE} state_e;

  state_e       state_q, state_d;
  logic [1:0]   sclk_sync_q, ssel_sync_q, mosi_sync_q;
  logic         sclk_prev_q;
  logic         sclk_s, ssel_s, mosi_s, sclk_rise;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]   shift_q, shift_d;
  logic [7:0]   byte_in;
  logic [3:0]   addr_q, addr_d;
  logic [7:0]   shadow_q [16];
  logic [7:0]   shadow_d [16];
  logic         dirty_q, dirty_d;
  logic [127:0] cfg_q, cfg_d;
  logic         wr_strobe_q, wr_strobe_d;
  logic         commit_q, commit_d;
`ifdef SPI_READBACK_EN
  logic         sclk_fall;
  logic [7:0]   rd_shift_q, rd_shift_d;
  logic         miso_q, miso_d;
`endif

  assign sclk_s    = sclk_sync_q[1];
  assign ssel_s    = ssel_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  // Only 7 bits are stored; the 8th arrives with the completing rise.
  assign byte_in   = {shift_q, mosi_s};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    shadow_d    = shadow_q;
    dirty_d     = dirty_q;
    cfg_d       = cfg_q;
    wr_strobe_d = 1'b0;
    commit_d    = 1'b0;
`ifdef SPI_READBACK_EN
    rd_shift_d  = rd_shift_q;
    miso_d      = miso_q;
`endif

    if (state_q == ST_IDLE || !ssel_s) begin
      // Dropping SSEL mid-byte discards the partial byte.
      bit_cnt_d = '0;
      shift_d   = '0;
`ifdef SPI_READBACK_EN
      rd_shift_d = '0;
      miso_d     = 1'b0;
`endif
      state_d   = ssel_s ? ST_CMD : ST_IDLE;
    end else begin
      if (sclk_rise) begin
        shift_d   = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              addr_d = byte_in[3:0];
              if (!byte_in[7]) begin
                state_d = ST_WDATA;
              end else begin
`ifdef SPI_READBACK_EN
                state_d    = ST_RDATA;
                rd_shift_d = shadow_q[byte_in[3:0]];
`else
                state_d    = ST_IGNORE;
`endif
              end
            end
            ST_WDATA: begin
              shadow_d[addr_q] = byte_in;
              wr_strobe_d      = 1'b1;
              dirty_d          = 1'b1;
              addr_d           = addr_q + 4'd1;
            end
`ifdef SPI_READBACK_EN
            ST_RDATA: begin
              addr_d     = addr_q + 4'd1;
              rd_shift_d = shadow_q[addr_q + 4'd1];
            end
`endif
            default: ;
          endcase
        end
      end
`ifdef SPI_READBACK_EN
      if (sclk_fall && state_q == ST_RDATA) begin
        miso_d     = rd_shift_q[7];
        rd_shift_d = {rd_shift_q[6:0], 1'b0};
      end
`endif
    end

    // A write always happens with busy=1, so it can never race a commit.
    if (frame_sync && dirty_q && !ssel_s) begin
      for (int n = 0; n < 16; n++) cfg_d[8*n +: 8] = shadow_q[n];
      dirty_d  = 1'b0;
      commit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ssel_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
      dirty_q     <= 1'b0;
      cfg_q       <= '0;
      wr_strobe_q <= 1'b0;
      commit_q    <= 1'b0;
`ifdef SPI_READBACK_EN
      rd_shift_q  <= '0;
      miso_q      <= 1'b0;
`endif
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], SCLK};
      ssel_sync_q <= {ssel_sync_q[0], SSEL};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      shadow_q    <= shadow_d;
      dirty_q     <= dirty_d;
      cfg_q       <= cfg_d;
      wr_strobe_q <= wr_strobe_d;
      commit_q    <= commit_d;
`ifdef SPI_READBACK_EN
      rd_shift_q  <= rd_shift_d;
      miso_q      <= miso_d;
`endif
    end
  end

`ifdef SPI_READBACK_EN
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign MISO      = miso_q;
`else
  assign MISO      = 1'b0;
`endif
  assign cfg       = cfg_q;
  assign wr_strobe = wr_strobe_q;
  assign commit    = commit_q;
  assign busy      = ssel_s;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
`timescale 1ns/1ps
module tb_spi_reg_ctrl;
  logic         clk = 1'b0;
  logic         reset, SCLK, SSEL, MOSI, frame_sync;
  logic         MISO, wr_strobe, commit, busy;
  logic [127:0] cfg;

  spi_reg_ctrl dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SSEL(SSEL), .MOSI(MOSI),
    .frame_sync(frame_sync), .MISO(MISO), .cfg(cfg),
    .wr_strobe(wr_strobe), .commit(commit), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int strobe_cnt = 0;

  // Reference model: plain arrays of register contents.
  logic [7:0] m_shadow [16];
  logic [7:0] m_active [16];
  bit         m_dirty;

  typedef struct {
    logic [7:0] cmd;
    int         nbytes;
    logic [7:0] d0, d1;
    int         part;
    logic [3:0] chk_reg;
    logic [7:0] chk_val;
    int         exp_strobes;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] m_cfg();
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = m_active[n];
    return r;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 16; n++) begin m_shadow[n] = '0; m_active[n] = '0; end
    m_dirty = 0;
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) if (wr_strobe) strobe_cnt++;

  // cfg may change only on a commit cycle (reset excepted).
  logic [127:0] prev_cfg = '0;
  logic         prev_rst = 1'b1;
  always @(negedge clk) begin
    if (!reset && !prev_rst && cfg !== prev_cfg) chk("cfg_only_on_commit", commit, 1);
    prev_cfg = cfg;
    prev_rst = reset;
  end

  task automatic spi_bit(input logic b, output logic r);
    MOSI = b;
    wclk(8);
    r = MISO;
    SCLK = 1'b1;
    wclk(8);
    SCLK = 1'b0;
  endtask

  task automatic do_frame(input string nm);
    bit exp_c;
    exp_c = m_dirty && !SSEL;
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    if (exp_c) begin
      for (int n = 0; n < 16; n++) m_active[n] = m_shadow[n];
      m_dirty = 0;
    end
    chk({nm, "_commit"}, commit, exp_c);
    chk({nm, "_cfg"}, cfg, m_cfg());
    @(negedge clk);
    chk({nm, "_commit_pulse_end"}, commit, 0);
  endtask

  // One transaction: cmd, nbytes full bytes, then part extra bits, then SSEL low
  // (unless keep_sel). fs_mid fires frame_sync while SSEL is still high.
  task automatic do_xact(input logic [7:0] cmd, input int nbytes,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input int part, input bit fs_mid, input bit keep_sel);
    logic [7:0] db, rx;
    logic       r;
    logic [3:0] a;
    int         exp_str;
    exp_str = 0;
    strobe_cnt = 0;
    rx = '0;
    SSEL = 1'b1;
    wclk(8);
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], r);
    a = cmd[3:0];
    for (int k = 0; k < nbytes; k++) begin
      db = (k == 0) ? d0 : (k == 1) ? d1 : d2;
      for (int i = 7; i >= 0; i--) begin spi_bit(db[i], r); rx[i] = r; end
      if (!cmd[7]) begin
        m_shadow[a] = db; m_dirty = 1; exp_str++; a = a + 4'd1;
      end else begin
`ifdef SPI_READBACK_EN
        chk("read_byte", rx, m_shadow[a]);
        a = a + 4'd1;
`else
        chk("miso_tied_low", rx, 0);
`endif
      end
    end
    for (int i = 0; i < part; i++) spi_bit(1'($urandom_range(0, 1)), r);
    wclk(8);
    if (fs_mid) do_frame("frame_while_busy");
    if (!keep_sel) begin
      SSEL = 1'b0;
      wclk(8);
      chk("busy_low_after_xact", busy, 0);
      chk("miso_low_after_xact", MISO, 0);
    end
    chk("wr_strobe_count", strobe_cnt, exp_str);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'h02, 2, 8'hA5, 8'h3C, 0, 4'd3,  8'h3C, 2};
    vecs[1] = '{8'h0F, 2, 8'h11, 8'h22, 0, 4'd0,  8'h22, 2};
    vecs[2] = '{8'h05, 1, 8'h77, 8'h00, 5, 4'd5,  8'h77, 1};
    vecs[3] = '{8'h06, 0, 8'h00, 8'h00, 5, 4'd6,  8'h00, 0};
    vecs[4] = '{8'h76, 1, 8'h5A, 8'h00, 0, 4'd6,  8'h5A, 1};
    vecs[5] = '{8'h84, 1, 8'hFF, 8'h00, 0, 4'd4,  8'h00, 0};

    reset = 1'b1; SCLK = 1'b0; SSEL = 1'b0; MOSI = 1'b0; frame_sync = 1'b0;
    model_reset();
    wclk(3);
    chk("rst_cfg", cfg, 0);
    chk("rst_outs", {MISO, wr_strobe, commit, busy}, 0);
    reset = 1'b0;
    wclk(4);

    do_frame("frame_not_dirty");

    foreach (vecs[v]) begin
      do_xact(vecs[v].cmd, vecs[v].nbytes, vecs[v].d0, vecs[v].d1, 8'h00,
              vecs[v].part, 1'b0, 1'b0);
      chk("vec_strobes", strobe_cnt, vecs[v].exp_strobes);
      chk("vec_cfg_before_commit", cfg, m_cfg());
      do_frame("vec_frame");
      chk("vec_reg", cfg[8*vecs[v].chk_reg +: 8], vecs[v].chk_val);
    end
    chk("wrap_reg15", cfg[127:120], 8'h11);
    chk("plan_reg2", cfg[23:16], 8'hA5);

    // frame_sync while busy is ignored; next idle frame_sync commits.
    do_xact(8'h08, 1, 8'h42, 8'h00, 8'h00, 0, 1'b1, 1'b1);
    SSEL = 1'b0;
    wclk(8);
    do_frame("frame_after_busy");
    chk("busy_commit_reg8", cfg[71:64], 8'h42);

    // Readback: reg4=C3 then read it (bits 1,1,0,0,0,0,1,1 on MISO).
    do_xact(8'h04, 1, 8'hC3, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    do_frame("rb_prep_frame");
    do_xact(8'h84, 2, 8'hFF, 8'hFF, 8'h00, 0, 1'b0, 1'b0);
    do_frame("rb_frame_no_change");
    chk("rb_reg4_kept", cfg[39:32], 8'hC3);

    // Random transactions against the model.
    for (int t = 0; t < 24; t++) begin
      logic [7:0] c;
      int nb, pb;
      c  = 8'($urandom);
      nb = $urandom_range(0, 3);
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      do_xact(c, nb, 8'($urandom), 8'($urandom), 8'($urandom), pb,
              1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) do_frame("rand_frame");
    end
    do_frame("rand_final_frame");

    // Reset in the middle of a data byte.
    SSEL = 1'b1;
    wclk(8);
    begin
      logic [7:0] cmd1;
      logic r;
      cmd1 = 8'h01;
      for (int i = 7; i >= 0; i--) spi_bit(cmd1[i], r);
      for (int i = 0; i < 4; i++) spi_bit(1'b1, r);
    end
    #3 reset = 1'b1;
    #1;
    chk("midrst_cfg", cfg, 0);
    chk("midrst_outs", {MISO, wr_strobe, commit, busy}, 0);
    model_reset();
    SSEL = 1'b0; SCLK = 1'b0;
    wclk(4);
    reset = 1'b0;
    wclk(4);
    do_xact(8'h03, 1, 8'h99, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    do_frame("post_rst_frame");
    chk("post_rst_reg3", cfg[31:24], 8'h99);
    chk("post_rst_reg2", cfg[23:16], 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
